fib_req_sequencer: RTL and testbench
====================================

# fib_req_sequencer

Request/response front-end for `fsm_num_gen`. It accepts Fibonacci jobs over a valid/ready request channel and drives the generator's level-sensitive load/clear protocol. It collects the generator's result or its error/overflow status, recovers the generator to IDLE, and returns the result with a status code and a cycle count over a valid/ready response channel. It sits directly upstream of `fsm_num_gen` and also consumes its outputs.

## Interface
Parameters:
- `DATA_WIDTH`, 64, seed/result width; must match the generator.
- `ORDER_WIDTH`, 16, order width; must match the generator.
- `CYC_WIDTH`, 32, width of the saturating compute-cycle counter.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  the block accepts a request this cycle.
- `req_data`  in  DATA_WIDTH  seed value.
- `req_order`  in  ORDER_WIDTH  sequence position.
- `rsp_valid`  out  1  a response is present.
- `rsp_ready`  in  1  the consumer accepts the response.
- `rsp_data`  out  DATA_WIDTH  result; 0 on ERR.
- `rsp_status`  out  2  0=OK, 1=ERR, 2=OVF; 3 is reserved.
- `rsp_cycles`  out  CYC_WIDTH  number of WAIT cycles, saturating.
- `gen_load`, `gen_clear`  out  1  drive the generator's `load` and `clear`.
- `gen_data`, `gen_order`  out  DATA_WIDTH/ORDER_WIDTH  drive the generator's `data_in` and `order`.
- `gen_data_out`  in  DATA_WIDTH  generator result.
- `gen_done`, `gen_overflow`, `gen_error`  in  1  generator status.

## Operation
- States: SETTLE, IDLE, LOAD1, LOAD2, WAIT, CLEAR, RESP.
- Reset (async assert) → SETTLE. Every output is 0, including `req_ready`.
- SETTLE → IDLE unconditionally after one cycle. This covers the generator's own RESET→IDLE cycle.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register `req_data`/`req_order` into `gen_data`/`gen_order`, clear the cycle counter, and go to LOAD1.
- LOAD1 and LOAD2: `gen_load`=1. LOAD1 → LOAD2 → WAIT. `gen_load` is high for exactly 2 consecutive cycles per job.
- `gen_data`/`gen_order` hold stable from LOAD1 until the next accept.
- WAIT:
  - The counter increments every cycle, saturating at all-ones.
  - Exit priority is `gen_done` > `gen_overflow` > `gen_error`.
  - `gen_done`: capture `gen_data_out`, status OK, go to RESP.
  - `gen_overflow`: capture `gen_data_out`, status OVF, go to CLEAR. `gen_error` also being high is ignored.
  - `gen_error` alone: `rsp_data`=0, status ERR, go to CLEAR.
  - `rsp_cycles` includes the terminating cycle.
- CLEAR: `gen_clear`=1 for exactly one cycle, then RESP. `gen_clear` is never asserted in any other state.
- RESP:
  - `rsp_valid`=1.
  - `rsp_data`, `rsp_status` and `rsp_cycles` are held stable while `rsp_ready`=0.
  - On `rsp_ready`, go to IDLE. `rsp_valid` drops the next cycle.
- The response registers keep their last value after the handshake; they are only meaningful while `rsp_valid`=1.
- No input validation: zero seed or zero order is forwarded, and the generator reports ERR.

## Timing
- Request accepted at cycle t (IDLE). `gen_load` is high at t+1 and t+2. WAIT starts at t+3.
- ERR path: the generator is in ERROR at t+3. `gen_clear` is high at t+4. `rsp_valid` is high at t+5. `rsp_cycles`=1.
- OK path: `rsp_valid` is high on the cycle after `gen_done` is sampled.
- Minimum accept-to-accept spacing is 5 cycles (OK path with a 1-cycle compute and `rsp_ready` held high).
- `req_ready` and `rsp_valid` are decoded from the registered state only; there is no combinational path from `req_valid` or `rsp_ready`.
- All `gen_*` outputs are registered.
- `reset_n` is shared with the generator. Assertion at any point returns both blocks to their reset states and drops the in-flight job. No response is produced for it.

## Structure
- Package `fib_seq_pkg` holds:
  - the `rsp_status_e` enum (OK/ERR/OVF);
  - the sequencer state enum;
  - the default-width constants shared with the generator.
- Sub-module `sat_counter` (`CYC_WIDTH` parameter; clear, enable, saturating increment) implements `rsp_cycles`.
- `fsm_num_gen` is not instantiated inside this block; it is connected at the next level up.

## Test plan
- **Basic OK:** behavioural generator stub asserts `gen_done` with `gen_data_out`=55 on the 7th WAIT cycle. Drive `req_data`=1, `req_order`=10 → `gen_load` high exactly 2 cycles, `rsp_data`=55, `rsp_status`=0, `rsp_cycles`=7.
- **Zero seed:** real `fsm_num_gen` attached, `req_data`=0, `req_order`=5, accepted at t → `gen_clear` pulse at t+4 only, response at t+5 with status 1, data 0, cycles 1. The generator's `error` is low afterwards.
- **Overflow:** stub raises `gen_overflow` and `gen_error` together, with `gen_data_out`=64'hFFFF_FFFF_FFFF_FFFF → status 2, data captured, one `gen_clear` pulse, and the next job completes OK.
- **Backpressure:** hold `rsp_ready`=0 for 6 cycles → response fields stable, `req_ready`=0, `gen_load`=0 throughout. Raise `rsp_ready` → IDLE, and the next `req_valid` is accepted.
- **Reset during WAIT:** assert `reset_n` mid-job → all outputs 0 immediately. After release, `req_ready`=0 for one cycle (SETTLE), then a new job completes normally with no stale response.
- **Counter saturation:** `CYC_WIDTH`=4, stub done after 20 WAIT cycles → `rsp_cycles`=15.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// Shared types and default widths for the Fibonacci request sequencer.
// The widths match the fsm_num_gen defaults.
package fib_seq_pkg;

  localparam int unsigned FIB_DATA_WIDTH  = 64;
  localparam int unsigned FIB_ORDER_WIDTH = 16;
  localparam int unsigned FIB_CYC_WIDTH   = 32;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_ERR = 2'd1,
    RSP_OVF = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD1  = 3'd2,
    ST_LOAD2  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CLEAR  = 3'd5,
    ST_RESP   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Used to measure generator compute cycles.
module sat_counter #(
  parameter int unsigned CYC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 enable_i,
  output logic [CYC_WIDTH-1:0] count_o
);

  localparam logic [CYC_WIDTH-1:0] CountOne = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

  logic [CYC_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + CountOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fib_req_sequencer.sv
// Valid/ready front-end for fsm_num_gen: loads a job, waits for done/overflow/error,
// clears the generator when needed and returns result, status and compute-cycle count.
module fib_req_sequencer
  import fib_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FIB_DATA_WIDTH,
  parameter int unsigned ORDER_WIDTH = FIB_ORDER_WIDTH,
  parameter int unsigned CYC_WIDTH   = FIB_CYC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [ORDER_WIDTH-1:0] req_order,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic [1:0]             rsp_status,
  output logic [CYC_WIDTH-1:0]   rsp_cycles,
  output logic                   gen_load,
  output logic                   gen_clear,
  output logic [DATA_WIDTH-1:0]  gen_data,
  output logic [ORDER_WIDTH-1:0] gen_order,
  input  logic [DATA_WIDTH-1:0]  gen_data_out,
  input  logic                   gen_done,
  input  logic                   gen_overflow,
  input  logic                   gen_error
);

  seq_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  gen_data_q, gen_data_d;
  logic [ORDER_WIDTH-1:0] gen_order_q, gen_order_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  rsp_status_e            rsp_status_q, rsp_status_d;
  logic                   gen_load_q, gen_load_d;
  logic                   gen_clear_q, gen_clear_d;
  logic                   cnt_clear, cnt_enable;

  always_comb begin
    state_d      = state_q;
    gen_data_d   = gen_data_q;
    gen_order_d  = gen_order_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    case (state_q)
      ST_SETTLE: state_d = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          gen_data_d  = req_data;
          gen_order_d = req_order;
          cnt_clear   = 1'b1;
          state_d     = ST_LOAD1;
        end
      end
      ST_LOAD1: state_d = ST_LOAD2;
      ST_LOAD2: state_d = ST_WAIT;
      ST_WAIT: begin
        // Priority: done beats overflow, overflow beats error.
        cnt_enable = 1'b1;
        if (gen_done) begin
          rsp_data_d   = gen_data_out;
          rsp_status_d = RSP_OK;
          state_d      = ST_RESP;
        end else if (gen_overflow) begin
          rsp_data_d   = gen_data_out;
          rsp_status_d = RSP_OVF;
          state_d      = ST_CLEAR;
        end else if (gen_error) begin
          rsp_data_d   = '0;
          rsp_status_d = RSP_ERR;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    // Generator controls are registered from the next state so they line up with it.
    gen_load_d  = (state_d == ST_LOAD1) || (state_d == ST_LOAD2);
    gen_clear_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SETTLE;
      gen_data_q   <= '0;
      gen_order_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= RSP_OK;
      gen_load_q   <= 1'b0;
      gen_clear_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gen_data_q   <= gen_data_d;
      gen_order_q  <= gen_order_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      gen_load_q   <= gen_load_d;
      gen_clear_q  <= gen_clear_d;
    end
  end

  sat_counter #(
    .CYC_WIDTH(CYC_WIDTH)
  ) u_cycles (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .count_o (rsp_cycles)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign gen_load   = gen_load_q;
  assign gen_clear  = gen_clear_q;
  assign gen_data   = gen_data_q;
  assign gen_order  = gen_order_q;

endmodule

// File: tb/tb_fib_req_sequencer.sv
// Scoreboard bench for fib_req_sequencer with a behavioural generator stub; a second
// instance with a 4-bit cycle counter shares the stub to observe saturation.
module tb_fib_req_sequencer;
  import fib_seq_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  status;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady, rspValid, rspReady;
  logic [63:0] reqData, rspData, genData, genDataOut;
  logic [15:0] reqOrder, genOrder;
  logic [1:0]  rspStatus;
  logic [31:0] rspCycles;
  logic        genLoad, genClear, genDone, genOverflow, genError;

  logic        reqReady1, rspValid1, genLoad1, genClear1;
  logic [63:0] rspData1, genData1;
  logic [15:0] genOrder1;
  logic [1:0]  rspStatus1;
  logic [3:0]  rspCycles1;

  int checks = 0;
  int failures = 0;
  int loadCnt = 0;
  int clearCnt = 0;
  exp_t sbQ[$];

  int          stubMode, stubDelay;
  logic [63:0] stubResult;
  logic        stubActive, stubAutoErr, stubHit;
  int          stubPc, effMode, effDelay;

  always #5 clk = ~clk;

  fib_req_sequencer #(.DATA_WIDTH(64), .ORDER_WIDTH(16), .CYC_WIDTH(32)) dut (
    .clk(clk), .reset_n(resetN), .req_valid(reqValid), .req_ready(reqReady),
    .req_data(reqData), .req_order(reqOrder), .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_data(rspData), .rsp_status(rspStatus), .rsp_cycles(rspCycles),
    .gen_load(genLoad), .gen_clear(genClear), .gen_data(genData), .gen_order(genOrder),
    .gen_data_out(genDataOut), .gen_done(genDone), .gen_overflow(genOverflow),
    .gen_error(genError));

  fib_req_sequencer #(.DATA_WIDTH(64), .ORDER_WIDTH(16), .CYC_WIDTH(4)) dutSat (
    .clk(clk), .reset_n(resetN), .req_valid(reqValid), .req_ready(reqReady1),
    .req_data(reqData), .req_order(reqOrder), .rsp_valid(rspValid1), .rsp_ready(rspReady),
    .rsp_data(rspData1), .rsp_status(rspStatus1), .rsp_cycles(rspCycles1),
    .gen_load(genLoad1), .gen_clear(genClear1), .gen_data(genData1), .gen_order(genOrder1),
    .gen_data_out(genDataOut), .gen_done(genDone), .gen_overflow(genOverflow),
    .gen_error(genError));

  // Generator stub: counts WAIT cycles from the end of load; zero seed/order forces ERR.
  assign effMode     = stubAutoErr ? 1 : stubMode;
  assign effDelay    = stubAutoErr ? 1 : stubDelay;
  assign stubHit     = stubActive && (stubPc == effDelay);
  assign genDone     = stubHit && (effMode == 0);
  assign genOverflow = stubHit && (effMode == 2);
  assign genError    = stubHit && ((effMode == 1) || (effMode == 2));
  assign genDataOut  = stubResult;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stubActive  <= 1'b0;
      stubPc      <= 0;
      stubAutoErr <= 1'b0;
    end else if (genLoad) begin
      stubActive  <= 1'b1;
      stubPc      <= 1;
      stubAutoErr <= (genData == 64'd0) || (genOrder == 16'd0);
    end else if (genClear) begin
      stubActive <= 1'b0;
      stubPc     <= 0;
    end else if (stubActive) begin
      if (stubHit && (effMode == 0)) stubActive <= 1'b0;
      else if (stubPc < effDelay) stubPc <= stubPc + 1;
    end
  end

  always @(negedge clk) begin
    if (genLoad === 1'b1) loadCnt <= loadCnt + 1;
    if (genClear === 1'b1) clearCnt <= clearCnt + 1;
  end

  function automatic int sat4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic setStub(input int mode, input int delay, input logic [63:0] result);
    stubMode = mode; stubDelay = delay; stubResult = result;
  endtask

  // Drives one request, pushes its expectation on accept; returns at the negedge of t+1.
  task automatic sendReq(input logic [63:0] d, input logic [15:0] o, input logic [63:0] ed,
                         input logic [1:0] es, input int ec, output bit accepted);
    accepted = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqData = d; reqOrder = o;
    for (int i = 0; i < 50; i++) begin
      if (reqReady === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) sbQ.push_back('{ed, es, ec});
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic waitRsp(output bit got, output logic [63:0] d, output logic [1:0] s,
                         output int c, output int c1);
    got = 1'b0; d = '0; s = '0; c = 0; c1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (rspValid === 1'b1) begin
        got = 1'b1; d = rspData; s = rspStatus; c = int'(rspCycles); c1 = int'(rspCycles1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({reqReady, rspValid, genLoad, genClear, rspStatus} !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {reqReady, rspValid, genLoad, genClear, rspStatus});
    end
    checks++;
    if ((rspData | genData | {48'd0, genOrder} | {32'd0, rspCycles}) !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected 0", rspData, genData, genOrder, rspCycles);
    end
    resetN = 1'b1;
    #1;
    checks++;
    if (reqReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL settle_ready: got %b expected 0", reqReady);
    end
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_ready: got %b expected 1", reqReady);
    end
  endtask

  task automatic test_basic_ok();
    bit acc, got; logic [63:0] d; logic [1:0] s; int c, c1, lb; exp_t e;
    setStub(0, 7, 64'd55); rspReady = 1'b1; lb = loadCnt;
    sendReq(64'd1, 16'd10, 64'd55, 2'd0, 7, acc);
    waitRsp(got, d, s, c, c1);
    checks++;
    if (!(acc && got)) begin
      failures++;
      $display("[TB] FAIL ok_handshake: got acc=%0d rsp=%0d expected 1/1", acc, got);
    end
    e = sbQ.pop_front();
    checks++;
    if (d !== e.data) begin failures++; $display("[TB] FAIL ok_data: got %0d expected %0d", d, e.data); end
    checks++;
    if (s !== e.status) begin failures++; $display("[TB] FAIL ok_status: got %0d expected %0d", s, e.status); end
    checks++;
    if (c !== e.cycles) begin failures++; $display("[TB] FAIL ok_cycles: got %0d expected %0d", c, e.cycles); end
    checks++;
    if (c1 !== sat4(e.cycles)) begin failures++; $display("[TB] FAIL ok_cycles4: got %0d expected %0d", c1, sat4(e.cycles)); end
    checks++;
    if (loadCnt - lb !== 2) begin failures++; $display("[TB] FAIL ok_load_len: got %0d expected 2", loadCnt - lb); end
  endtask

  task automatic test_zero_seed();
    bit acc; exp_t e;
    setStub(0, 5, 64'hDEAD); rspReady = 1'b1;
    sendReq(64'd0, 16'd5, 64'd0, 2'd1, 1, acc);
    checks++;
    if ({acc, genLoad, genClear, genData == 64'd0, genOrder == 16'd5} !== 5'b11011) begin
      failures++;
      $display("[TB] FAIL zero_t1: got %b expected 11011", {acc, genLoad, genClear, genData == 64'd0, genOrder == 16'd5});
    end
    @(negedge clk);
    checks++;
    if ({genLoad, genClear} !== 2'b10) begin failures++; $display("[TB] FAIL zero_t2: got %b expected 10", {genLoad, genClear}); end
    @(negedge clk);
    checks++;
    if ({genLoad, genClear, rspValid} !== 3'b000) begin failures++; $display("[TB] FAIL zero_t3: got %b expected 000", {genLoad, genClear, rspValid}); end
    @(negedge clk);
    checks++;
    if ({genClear, rspValid} !== 2'b10) begin failures++; $display("[TB] FAIL zero_t4: got %b expected 10", {genClear, rspValid}); end
    @(negedge clk);
    checks++;
    if ({rspValid, genClear, genError} !== 3'b100) begin failures++; $display("[TB] FAIL zero_t5: got %b expected 100", {rspValid, genClear, genError}); end
    e = sbQ.pop_front();
    checks++;
    if ({rspData, rspStatus, rspCycles} !== {e.data, e.status, 32'(e.cycles)}) begin
      failures++;
      $display("[TB] FAIL zero_rsp: got %0d/%0d/%0d expected %0d/%0d/%0d", rspData, rspStatus, rspCycles, e.data, e.status, e.cycles);
    end
    @(negedge clk);
    checks++;
    if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL zero_drop: got %b expected 0", rspValid); end
  endtask

  task automatic test_overflow();
    bit acc, got; logic [63:0] d; logic [1:0] s; int c, c1, cb; exp_t e;
    setStub(2, 3, 64'hFFFF_FFFF_FFFF_FFFF); rspReady = 1'b1; cb = clearCnt;
    sendReq(64'd3, 16'd90, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 3, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || s !== e.status || c !== e.cycles) begin
      failures++;
      $display("[TB] FAIL ovf_rsp: got %h/%0d/%0d expected %h/%0d/%0d", d, s, c, e.data, e.status, e.cycles);
    end
    checks++;
    if (clearCnt - cb !== 1) begin failures++; $display("[TB] FAIL ovf_clear: got %0d expected 1", clearCnt - cb); end
    setStub(0, 2, 64'h1234);
    sendReq(64'd5, 16'd7, 64'h1234, 2'd0, 2, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || s !== e.status || c !== e.cycles) begin
      failures++;
      $display("[TB] FAIL ovf_next: got %h/%0d/%0d expected %h/%0d/%0d", d, s, c, e.data, e.status, e.cycles);
    end
  endtask

  task automatic test_back_to_back();
    int accAt[$]; int rspSeen; exp_t e;
    rspSeen = 0;
    setStub(0, 1, 64'd21); rspReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b1; reqData = 64'd1; reqOrder = 16'd8;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (reqValid && (reqReady === 1'b1)) begin
        accAt.push_back(cyc);
        sbQ.push_back('{64'd21, 2'd0, 1});
      end
      if (rspValid === 1'b1) begin
        rspSeen++;
        e = sbQ.pop_front();
        checks++;
        if ({rspData, rspStatus, rspCycles} !== {e.data, e.status, 32'(e.cycles)}) begin
          failures++;
          $display("[TB] FAIL b2b_rsp: got %0d/%0d/%0d expected %0d/%0d/%0d", rspData, rspStatus, rspCycles, e.data, e.status, e.cycles);
        end
      end
      @(negedge clk);
      if (accAt.size() >= 2) reqValid = 1'b0;
    end
    checks++;
    if (accAt.size() != 2 || rspSeen != 2) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d accepts %0d rsps expected 2/2", accAt.size(), rspSeen);
    end else begin
      checks++;
      if (accAt[1] - accAt[0] != 5) begin
        failures++;
        $display("[TB] FAIL b2b_spacing: got %0d expected 5", accAt[1] - accAt[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, got; logic [63:0] d; logic [1:0] s; int c, c1, lb; exp_t e;
    setStub(0, 4, 64'd99); rspReady = 1'b0;
    sendReq(64'd2, 16'd11, 64'd99, 2'd0, 4, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || s !== e.status || c !== e.cycles) begin
      failures++;
      $display("[TB] FAIL bp_rsp: got %0d/%0d/%0d expected %0d/%0d/%0d", d, s, c, e.data, e.status, e.cycles);
    end
    lb = loadCnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({rspValid, reqReady, genLoad} !== 3'b100 || rspData !== e.data || rspStatus !== e.status || rspCycles !== 32'(e.cycles)) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got %b %0d/%0d/%0d expected 100 %0d/%0d/%0d", i, {rspValid, reqReady, genLoad}, rspData, rspStatus, rspCycles, e.data, e.status, e.cycles);
      end
    end
    checks++;
    if (loadCnt != lb) begin failures++; $display("[TB] FAIL bp_load: got %0d expected 0", loadCnt - lb); end
    rspReady = 1'b1;
    @(negedge clk);
    checks++;
    if ({rspValid, reqReady} !== 2'b01) begin failures++; $display("[TB] FAIL bp_release: got %b expected 01", {rspValid, reqReady}); end
    setStub(0, 3, 64'd77);
    sendReq(64'd6, 16'd12, 64'd77, 2'd0, 3, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || s !== e.status || c !== e.cycles) begin
      failures++;
      $display("[TB] FAIL bp_next: got %0d/%0d/%0d expected %0d/%0d/%0d", d, s, c, e.data, e.status, e.cycles);
    end
  endtask

  task automatic test_reset_wait();
    bit acc, got; logic [63:0] d; logic [1:0] s; int c, c1; exp_t e;
    setStub(0, 10, 64'd5); rspReady = 1'b1;
    sendReq(64'd1, 16'd20, 64'd5, 2'd0, 10, acc);
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    #1;
    if (acc) void'(sbQ.pop_back());
    checks++;
    if ({reqReady, rspValid, genLoad, genClear, rspStatus} !== 6'd0 ||
        (rspData | genData | {48'd0, genOrder} | {32'd0, rspCycles}) !== 64'd0) begin
      failures++;
      $display("[TB] FAIL rst_wait_zero: got %b %h/%h/%h expected all 0", {reqReady, rspValid, genLoad, genClear, rspStatus}, rspData, genData, rspCycles);
    end
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checks++;
    if ({reqReady, rspValid} !== 2'b00) begin failures++; $display("[TB] FAIL rst_settle: got %b expected 00", {reqReady, rspValid}); end
    @(negedge clk);
    checks++;
    if ({reqReady, rspValid} !== 2'b10) begin failures++; $display("[TB] FAIL rst_idle: got %b expected 10", {reqReady, rspValid}); end
    setStub(0, 2, 64'd8);
    sendReq(64'd4, 16'd4, 64'd8, 2'd0, 2, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || s !== e.status || c !== e.cycles || sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL rst_next: got %0d/%0d/%0d q=%0d expected %0d/%0d/%0d q=0", d, s, c, sbQ.size(), e.data, e.status, e.cycles);
    end
  endtask

  task automatic test_saturation();
    bit acc, got; logic [63:0] d; logic [1:0] s; int c, c1; exp_t e;
    setStub(0, 20, 64'd7); rspReady = 1'b1;
    sendReq(64'd1, 16'd3, 64'd7, 2'd0, 20, acc);
    waitRsp(got, d, s, c, c1);
    e = sbQ.pop_front();
    checks++;
    if ({acc, got} !== 2'b11 || d !== e.data || c !== e.cycles) begin
      failures++;
      $display("[TB] FAIL sat_wide: got %0d/%0d expected %0d/%0d", d, c, e.data, e.cycles);
    end
    checks++;
    if (c1 !== sat4(e.cycles)) begin failures++; $display("[TB] FAIL sat_narrow: got %0d expected %0d", c1, sat4(e.cycles)); end
  endtask

  initial begin
    resetN = 1'b0; reqValid = 1'b0; reqData = '0; reqOrder = '0; rspReady = 1'b0;
    setStub(0, 1, 64'd0);
    test_reset();
    test_basic_ok();
    test_zero_seed();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
